// File: rtl/sm4_cipher_core_if.sv
// SM4 core handshake bundle: round-key bus, input block and result channels.
// The master drives blocks and keys; the slave is the cipher core.
interface sm4_cipher_core_if;
    logic [1023:0] RK_i;
    logic          RK_READY_i;
    logic [127:0]  DIN_i;
    logic          DEC_i;
    logic          DIN_VALID_i;
    logic          DIN_READY_o;
    logic [127:0]  DOUT_o;
    logic          DOUT_VALID_o;
    logic          DOUT_READY_i;

    modport master (
        output RK_i, RK_READY_i, DIN_i, DEC_i, DIN_VALID_i, DOUT_READY_i,
        input  DIN_READY_o, DOUT_o, DOUT_VALID_o
    );

    modport slave (
        input  RK_i, RK_READY_i, DIN_i, DEC_i, DIN_VALID_i, DOUT_READY_i,
        output DIN_READY_o, DOUT_o, DOUT_VALID_o
    );
endinterface

// File: rtl/sm4_cipher_core.sv
// Iterative SM4 encrypt/decrypt datapath, UNROLL rounds per clock.
// Round keys are latched on accept so the key bus may change mid-block.
module sm4_cipher_core #(
    parameter int UNROLL = 1
) (
    input  logic              CLK_i,
    input  logic              RST_i,
    sm4_cipher_core_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [4:0] LAST = 5'(32 - UNROLL);
    localparam logic [4:0] STEP = 5'(UNROLL);

    // Entry 0 sits in the top byte, so it is addressed by the inverted index.
    localparam logic [255:0][7:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    function automatic logic [31:0] sbox_32b(input logic [31:0] w);
        return {SBOX[~w[31:24]], SBOX[~w[23:16]],
                SBOX[~w[15:8]],  SBOX[~w[7:0]]};
    endfunction

    function automatic logic [31:0] l_fn(input logic [31:0] b);
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
                 ^ {b[13:0], b[31:14]} ^ {b[7:0],  b[31:8]};
    endfunction

    state_t          state_q;
    logic [4:0]      cnt_q;
    logic [31:0]     x0_q, x1_q, x2_q, x3_q;
    logic            dec_q;
    logic [1023:0]   rk_q;
    logic [127:0]    dout_q;
    logic            dout_valid_q;

    logic [31:0]     w0, w1, w2, w3, t;
    logic [4:0]      n, idx;
    logic            accept;

    assign bus.DIN_READY_o  = (state_q == IDLE) && bus.RK_READY_i && !RST_i;
    assign bus.DOUT_o       = dout_q;
    assign bus.DOUT_VALID_o = dout_valid_q;
    assign accept           = bus.DIN_VALID_i && bus.DIN_READY_o;

    // Window slides by one word per round: w0..w3 = X[n..n+3].
    always_comb begin
        w0  = x0_q;
        w1  = x1_q;
        w2  = x2_q;
        w3  = x3_q;
        n   = '0;
        idx = '0;
        t   = '0;
        for (int u = 0; u < UNROLL; u++) begin
            n   = cnt_q + 5'(u);
            idx = dec_q ? 5'd31 - n : n;
            t   = w0 ^ l_fn(sbox_32b(w1 ^ w2 ^ w3 ^
                  rk_q[1023 - 32 * int'(idx) -: 32]));
            w0  = w1;
            w1  = w2;
            w2  = w3;
            w3  = t;
        end
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        x0_q    <= bus.DIN_i[127:96];
                        x1_q    <= bus.DIN_i[95:64];
                        x2_q    <= bus.DIN_i[63:32];
                        x3_q    <= bus.DIN_i[31:0];
                        dec_q   <= bus.DEC_i;
                        rk_q    <= bus.RK_i;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    x0_q  <= w0;
                    x1_q  <= w1;
                    x2_q  <= w2;
                    x3_q  <= w3;
                    cnt_q <= cnt_q + STEP;
                    if (cnt_q == LAST) begin
                        dout_q       <= {w3, w2, w1, w0};
                        dout_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (bus.DOUT_READY_i) begin
                        dout_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sm4_cipher_core.md
Name: sm4_cipher_core

Overview:
Iterative SM4 block-cipher datapath. It consumes the 32 round keys produced by the key-expansion pipeline, delivered as a 1024-bit bus plus a ready flag. It encrypts or decrypts one 128-bit block at a time, one round (or UNROLL rounds) per clock. Upstream and downstream both use valid/ready handshakes.

Parameters:
UNROLL, 1, rounds computed per clock; legal values 1, 2, 4; RUN length = 32/UNROLL cycles

Ports:
CLK_i  input  1  clock; all logic on rising edge
RST_i  input  1  synchronous reset, active-high
RK_i  input  1024  round keys; rk0 = RK_i[1023:992], rk_j = RK_i[1023-32j -: 32], rk31 = RK_i[31:0]
RK_READY_i  input  1  round-key bus valid
DIN_i  input  128  input block; X0 = DIN_i[127:96] ... X3 = DIN_i[31:0]
DEC_i  input  1  0 = encrypt, 1 = decrypt; sampled with DIN_i
DIN_VALID_i  input  1  input block valid
DIN_READY_o  output  1  core can accept a block
DOUT_o  output  128  result block
DOUT_VALID_o  output  1  result valid
DOUT_READY_i  input  1  downstream accepts result

Behaviour:
- Reset (RST_i = 1 at an edge), effective next cycle:
  - state = IDLE; round counter = 0; DOUT_o = 0; DOUT_VALID_o = 0.
  - DIN_READY_o = 0 while RST_i is high.
- Reset mid-RUN or mid-DONE aborts the block. No DOUT_VALID_o pulse follows.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - DIN_READY_o = RK_READY_i (combinational, gated by state == IDLE and !RST_i).
  - Accept on an edge with DIN_VALID_i & DIN_READY_o. On that edge:
    - load X0..X3 from DIN_i;
    - latch DEC_i;
    - latch all of RK_i into an internal 1024-bit register;
    - clear counter; go to RUN.
  - DIN_VALID_i high while RK_READY_i is low: no accept, core stays IDLE.
- RUN:
  - Each edge applies UNROLL rounds.
  - Round n (n = 0..31): X[n+4] = X[n] ^ T(X[n+1] ^ X[n+2] ^ X[n+3] ^ k_n).
  - T = L(tau(.)). tau = four byte S-boxes (reuse sbox_32b). L(B) = B ^ (B<<<2) ^ (B<<<10) ^ (B<<<18) ^ (B<<<24).
  - Key selection: encrypt k_n = rk_n; decrypt k_n = rk_(31-n), taken from the latched copy.
  - Counter advances by UNROLL per edge.
  - On the edge that completes round 31: DOUT_o <= {X35, X34, X33, X32} (reverse transform R), DOUT_VALID_o <= 1, state = DONE.
- Latency: DOUT_VALID_o rises 32/UNROLL cycles after the accepting edge (32 for UNROLL = 1).
- Key-bus independence: changes on RK_i, and RK_READY_i falling, during RUN/DONE have no effect on the block in flight.
- DONE:
  - DOUT_o and DOUT_VALID_o hold stable until DOUT_READY_i = 1 at an edge. On that edge DOUT_VALID_o <= 0 and state = IDLE.
  - DIN_READY_o = 0 in RUN and DONE. There is no same-cycle re-accept, so minimum block period = 32/UNROLL + 2 cycles.
- DOUT_o holds its last value after the handshake until the next completion.
- DIN_READY_o must not depend combinationally on DIN_VALID_i.
- DOUT_VALID_o is registered.

Test Plan:
1. Encrypt, standard vector:
   - Stimulus: RK_i = expansion of MK 0123456789abcdeffedcba9876543210 (rk0 = f12186f9, rk31 = 9124a012); RK_READY_i = 1; DIN_i = 0123456789abcdeffedcba9876543210; DEC_i = 0.
   - Required: DOUT_o = 681edf34d206965e86b3e94f536e4246, with DOUT_VALID_o rising exactly 32 cycles after accept.
2. Decrypt, same key:
   - Stimulus: DIN_i = 681edf34d206965e86b3e94f536e4246, DEC_i = 1.
   - Required: DOUT_o = 0123456789abcdeffedcba9876543210.
3. Backpressure:
   - Stimulus: hold DOUT_READY_i = 0 for 10 cycles after completion.
   - Required: DOUT_o and DOUT_VALID_o stay stable; DIN_READY_o = 0 throughout; the block is released on the first DOUT_READY_i = 1 edge; DIN_READY_o = 1 the following cycle.
4. Key gating and key-bus independence:
   - Stimulus: RK_READY_i = 0 with DIN_VALID_i = 1 for 5 cycles.
   - Required: DIN_READY_o = 0 and no accept.
   - Stimulus: after accept, drive RK_i = 0 and RK_READY_i = 0 during RUN.
   - Required: result still 681edf34d206965e86b3e94f536e4246.
5. Reset mid-RUN:
   - Stimulus: assert RST_i for 1 cycle at round 15.
   - Required: DOUT_VALID_o stays 0; DOUT_o = 0; the next block (vector 1) completes correctly.
6. UNROLL = 2 and 4:
   - Stimulus: rerun scenarios 1 and 2.
   - Required: identical DOUT_o; latency 16 and 8 cycles respectively.
